// File: rtl/lcb_distributor_n.sv
// N-channel arbiter sharing one ping-pong memory write/read port among lcbFull receivers.
// Busy-driven round-robin ownership, latency-aligned read-return routing, watchdog and drop counter.
module lcb_distributor_n #(
  parameter int CH      = 2,
  parameter int DW      = 12,
  parameter int AW      = 10,
  parameter int RD_LAT  = 2,
  parameter int MAX_OWN = 4096,
  parameter int CNTW    = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [CH-1:0]        busy,
  input  logic [CH*DW-1:0]     wrdOut,
  input  logic [CH*AW-1:0]     wrdAddr,
  input  logic [CH-1:0]        wren,
  input  logic [CH*AW-1:0]     oldWrdAddr,
  input  logic [CH-1:0]        oldRdEn,
  output logic [CH*DW-1:0]     oldWrd,
  output logic [DW-1:0]        commWrdOut,
  output logic [AW-1:0]        commWrdAddr,
  output logic                 commWren,
  output logic [AW-1:0]        commOldWrdAddr,
  output logic                 commOldRdEn,
  input  logic [DW-1:0]        commOldWrd,
  output logic [CH-1:0]        grant,
  output logic [CNTW-1:0]      drop_cnt,
  output logic                 wdog
);

  localparam int IW  = $clog2(CH);
  localparam int OCW = $clog2(MAX_OWN);
  localparam int DCW = $clog2(RD_LAT) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_OWN,
    S_DRAIN
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [OCW-1:0]  own_cnt_q, own_cnt_d;
  logic [DCW-1:0]  drain_cnt_q, drain_cnt_d;
  logic            wdog_q, wdog_d;
  logic [CNTW-1:0] drop_q, drop_d;
  logic            tag_vld_q [RD_LAT];
  logic            tag_vld_d [RD_LAT];
  logic [IW-1:0]   tag_idx_q [RD_LAT];
  logic [IW-1:0]   tag_idx_d [RD_LAT];

  logic            sel_found;
  logic [IW-1:0]   sel_idx;
  logic [IW-1:0]   cand_idx;
  logic            drop_hit;

  // While owning, ptr_q is the owner index; it stays put afterwards so the
  // next scan starts one past the previous owner.
  genvar gi;
  generate
    for (gi = 0; gi < CH; gi++) begin : g_grant
      assign grant[gi] = (state_q == S_OWN) && (ptr_q == IW'(gi));
    end
  endgenerate

  always_comb begin
    sel_found = 1'b0;
    sel_idx   = ptr_q;
    cand_idx  = ptr_q;
    for (int k = 1; k <= CH; k++) begin
      cand_idx = IW'((int'(ptr_q) + k) % CH);
      if (!sel_found && busy[cand_idx]) begin
        sel_found = 1'b1;
        sel_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    commWrdOut     = '0;
    commWrdAddr    = '0;
    commWren       = 1'b0;
    commOldWrdAddr = '0;
    commOldRdEn    = 1'b0;
    if (state_q == S_OWN) begin
      commWrdOut     = wrdOut[int'(ptr_q)*DW +: DW];
      commWrdAddr    = wrdAddr[int'(ptr_q)*AW +: AW];
      commWren       = wren[ptr_q];
      commOldWrdAddr = oldWrdAddr[int'(ptr_q)*AW +: AW];
      commOldRdEn    = oldRdEn[ptr_q];
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    own_cnt_d   = own_cnt_q;
    drain_cnt_d = drain_cnt_q;
    wdog_d      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (sel_found) begin
          state_d   = S_OWN;
          ptr_d     = sel_idx;
          own_cnt_d = '0;
        end
      end
      S_OWN: begin
        // A voluntary release takes precedence over the watchdog.
        if (!busy[ptr_q]) begin
          state_d     = S_DRAIN;
          drain_cnt_d = '0;
        end else if (own_cnt_q == OCW'(MAX_OWN - 1)) begin
          state_d     = S_DRAIN;
          drain_cnt_d = '0;
          wdog_d      = 1'b1;
        end else begin
          own_cnt_d = own_cnt_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (drain_cnt_q == DCW'(RD_LAT - 1)) begin
          state_d = S_IDLE;
        end else begin
          drain_cnt_d = drain_cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign drop_hit = |((wren | oldRdEn) & ~grant);

  always_comb begin
    drop_d = drop_q;
    if (drop_hit && (drop_q != {CNTW{1'b1}})) begin
      drop_d = drop_q + 1'b1;
    end
  end

  // Tag pipe follows each read through the memory latency so the return
  // lands on the channel that issued it, even after ownership has moved on.
  generate
    for (gi = 0; gi < RD_LAT; gi++) begin : g_tag
      if (gi == 0) begin : g_head
        assign tag_vld_d[gi] = commOldRdEn;
        assign tag_idx_d[gi] = ptr_q;
      end else begin : g_body
        assign tag_vld_d[gi] = tag_vld_q[gi-1];
        assign tag_idx_d[gi] = tag_idx_q[gi-1];
      end
    end
  endgenerate

  generate
    for (gi = 0; gi < CH; gi++) begin : g_ret
      assign oldWrd[gi*DW +: DW] =
        (tag_vld_q[RD_LAT-1] && (tag_idx_q[RD_LAT-1] == IW'(gi))) ? commOldWrd : '0;
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      ptr_q       <= IW'(CH - 1);
      own_cnt_q   <= '0;
      drain_cnt_q <= '0;
      wdog_q      <= 1'b0;
      drop_q      <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        tag_vld_q[i] <= 1'b0;
        tag_idx_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      own_cnt_q   <= own_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      wdog_q      <= wdog_d;
      drop_q      <= drop_d;
      for (int i = 0; i < RD_LAT; i++) begin
        tag_vld_q[i] <= tag_vld_d[i];
        tag_idx_q[i] <= tag_idx_d[i];
      end
    end
  end

  assign wdog     = wdog_q;
  assign drop_cnt = drop_q;

endmodule

// File: tb/tb_lcb_distributor_n.sv
// Randomised scoreboard bench for lcb_distributor_n: a per-cycle behavioural model pushes
// expected outputs into queues and a negedge monitor pops and compares them.
module tb_lcb_distributor_n;

  localparam int CH      = 4;
  localparam int DW      = 12;
  localparam int AW      = 10;
  localparam int RD_LAT  = 2;
  localparam int MAX_OWN = 16;
  localparam int CNTW    = 8;
  localparam int DROP_MAX = (1 << CNTW) - 1;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic [CH-1:0]       busy = '0;
  logic [CH*DW-1:0]    wrdOut = '0;
  logic [CH*AW-1:0]    wrdAddr = '0;
  logic [CH-1:0]       wren = '0;
  logic [CH*AW-1:0]    oldWrdAddr = '0;
  logic [CH-1:0]       oldRdEn = '0;
  logic [CH*DW-1:0]    oldWrd;
  logic [DW-1:0]       commWrdOut;
  logic [AW-1:0]       commWrdAddr;
  logic                commWren;
  logic [AW-1:0]       commOldWrdAddr;
  logic                commOldRdEn;
  logic [DW-1:0]       commOldWrd = '0;
  logic [CH-1:0]       grant;
  logic [CNTW-1:0]     drop_cnt;
  logic                wdog;

  lcb_distributor_n #(
    .CH(CH), .DW(DW), .AW(AW), .RD_LAT(RD_LAT), .MAX_OWN(MAX_OWN), .CNTW(CNTW)
  ) dut (
    .clk(clk), .reset(reset), .busy(busy), .wrdOut(wrdOut), .wrdAddr(wrdAddr),
    .wren(wren), .oldWrdAddr(oldWrdAddr), .oldRdEn(oldRdEn), .oldWrd(oldWrd),
    .commWrdOut(commWrdOut), .commWrdAddr(commWrdAddr), .commWren(commWren),
    .commOldWrdAddr(commOldWrdAddr), .commOldRdEn(commOldRdEn), .commOldWrd(commOldWrd),
    .grant(grant), .drop_cnt(drop_cnt), .wdog(wdog)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [CH-1:0]   grant;
    logic            wdog;
    logic [CNTW-1:0] drop;
    logic            cwren;
    logic            crd;
    logic [DW-1:0]   cdata;
    logic [AW-1:0]   caddr;
    logic [AW-1:0]   craddr;
  } status_t;

  typedef struct {
    int             due;
    int             idx;
    logic [DW-1:0]  data;
  } rd_t;

  status_t sq[$];
  rd_t     rq[$];
  logic [CH-1:0] glog[$];

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  bit mon_en = 1'b0;
  bit log_en = 1'b0;
  int wd_seen = 0;
  int ret_seen = 0;
  logic [CH*DW-1:0] last_ret = '0;
  logic [CH-1:0] prev_grant = '0;

  // reference model: who owns, for how long, and what is left of the drain gap
  int m_mode;   // 0 idle, 1 owned, 2 draining
  int m_owner;
  int m_rr;
  int m_held;
  int m_left;
  int m_drops;
  bit m_wd;

  bit            h_en [RD_LAT];
  logic [AW-1:0] h_addr [RD_LAT];
  bit            cap_en = 1'b0;
  logic [AW-1:0] cap_addr = '0;

  status_t          ms;
  rd_t              mr;
  logic [CH*DW-1:0] exp_rd;
  logic [CH-1:0]    rb;
  logic [CH-1:0]    exp_order [4];

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [DW-1:0] memf(input logic [AW-1:0] a);
    if (a == AW'(10'h155)) return DW'(12'hABC);
    return DW'((int'(a) * 13 + 7) % 4095 + 1);
  endfunction

  task automatic model_reset();
    m_mode = 0; m_owner = 0; m_rr = CH - 1; m_held = 0; m_left = 0; m_drops = 0; m_wd = 1'b0;
  endtask

  task automatic model_edge();
    logic [CH-1:0] g;
    bit found;
    int c;
    g = '0;
    if (m_mode == 1) g[m_owner] = 1'b1;
    if ((((wren | oldRdEn) & ~g) != '0) && (m_drops < DROP_MAX)) m_drops++;
    m_wd = 1'b0;
    case (m_mode)
      0: begin
        found = 1'b0;
        for (int k = 1; k <= CH; k++) begin
          c = (m_rr + k) % CH;
          if (!found && busy[c]) begin
            found = 1'b1; m_owner = c; m_rr = c; m_held = 0; m_mode = 1;
          end
        end
      end
      1: begin
        if (!busy[m_owner]) begin
          m_mode = 2; m_left = RD_LAT;
        end else if (m_held == MAX_OWN - 1) begin
          m_mode = 2; m_left = RD_LAT; m_wd = 1'b1;
        end else begin
          m_held++;
        end
      end
      default: begin
        m_left--;
        if (m_left == 0) m_mode = 0;
      end
    endcase
  endtask

  task automatic push_expect();
    status_t s;
    s = '0;
    if (m_mode == 1) begin
      s.grant[m_owner] = 1'b1;
      s.cwren  = wren[m_owner];
      s.crd    = oldRdEn[m_owner];
      s.cdata  = wrdOut[m_owner*DW +: DW];
      s.caddr  = wrdAddr[m_owner*AW +: AW];
      s.craddr = oldWrdAddr[m_owner*AW +: AW];
      if (oldRdEn[m_owner]) rq.push_back('{cyc + RD_LAT, m_owner, memf(oldWrdAddr[m_owner*AW +: AW])});
    end
    s.wdog = m_wd;
    s.drop = CNTW'(m_drops);
    sq.push_back(s);
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    model_edge();
    for (int k = RD_LAT - 1; k > 0; k--) begin
      h_en[k] = h_en[k-1];
      h_addr[k] = h_addr[k-1];
    end
    h_en[0] = cap_en;
    h_addr[0] = cap_addr;
    commOldWrd = h_en[RD_LAT-1] ? memf(h_addr[RD_LAT-1]) : DW'($urandom);
    cyc++;
  endtask

  task automatic drive(input logic [CH-1:0] b, input logic [CH-1:0] w, input logic [CH-1:0] r, input int ovr);
    busy = b; wren = w; oldRdEn = r;
    for (int c = 0; c < CH; c++) begin
      wrdOut[c*DW +: DW]     = DW'($urandom);
      wrdAddr[c*AW +: AW]    = AW'($urandom);
      oldWrdAddr[c*AW +: AW] = (ovr >= 0) ? AW'(ovr) : AW'($urandom);
    end
    push_expect();
    #2;
    cap_en = commOldRdEn;
    cap_addr = commOldWrdAddr;
  endtask

  task automatic step(input logic [CH-1:0] b, input logic [CH-1:0] w, input logic [CH-1:0] r, input int ovr);
    advance();
    drive(b, w, r, ovr);
  endtask

  task automatic hit_reset(input bit check);
    mon_en = 1'b0;
    #1;
    reset = 1'b0;
    #1;
    if (check) begin
      chk("rst_grant", 64'(grant), 64'(0));
      chk("rst_cwren", 64'(commWren), 64'(0));
      chk("rst_crden", 64'(commOldRdEn), 64'(0));
      chk("rst_cdata", 64'(commWrdOut), 64'(0));
      chk("rst_caddr", 64'(commWrdAddr), 64'(0));
      chk("rst_craddr", 64'(commOldWrdAddr), 64'(0));
      chk("rst_oldwrd", 64'(oldWrd), 64'(0));
      chk("rst_wdog", 64'(wdog), 64'(0));
      chk("rst_drop", 64'(drop_cnt), 64'(0));
    end
    busy = '0; wren = '0; oldRdEn = '0;
    sq.delete();
    rq.delete();
    model_reset();
    cap_en = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b1;
    mon_en = 1'b1;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (sq.size() > 0) begin
        ms = sq.pop_front();
        chk("grant", 64'(grant), 64'(ms.grant));
        chk("wdog", 64'(wdog), 64'(ms.wdog));
        chk("drop_cnt", 64'(drop_cnt), 64'(ms.drop));
        chk("commWren", 64'(commWren), 64'(ms.cwren));
        chk("commOldRdEn", 64'(commOldRdEn), 64'(ms.crd));
        chk("commWrdOut", 64'(commWrdOut), 64'(ms.cdata));
        chk("commWrdAddr", 64'(commWrdAddr), 64'(ms.caddr));
        chk("commOldWrdAddr", 64'(commOldWrdAddr), 64'(ms.craddr));
      end
      exp_rd = '0;
      if (rq.size() > 0 && rq[0].due == cyc) begin
        mr = rq.pop_front();
        exp_rd[mr.idx*DW +: DW] = mr.data;
      end
      chk("oldWrd", 64'(oldWrd), 64'(exp_rd));
      if (wdog) wd_seen++;
      if (oldWrd != '0) begin
        ret_seen++;
        last_ret = oldWrd;
      end
      if (log_en && grant != '0 && prev_grant == '0) glog.push_back(grant);
    end
    prev_grant = grant;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    for (int k = 0; k < RD_LAT; k++) begin
      h_en[k] = 1'b0;
      h_addr[k] = '0;
    end
    exp_order[0] = 4'b0001; exp_order[1] = 4'b0010; exp_order[2] = 4'b1000; exp_order[3] = 4'b0001;

    hit_reset(1'b1);

    // single owner ch2 with three writes
    for (int i = 0; i < 10; i++)
      step(4'b0100, (i == 2 || i == 4 || i == 6) ? 4'b0100 : 4'b0000, '0, -1);
    repeat (6) step('0, '0, '0, -1);

    // round-robin order with every owner releasing after five cycles
    hit_reset(1'b0);
    glog.delete();
    log_en = 1'b1;
    for (int i = 0; i < 200 && glog.size() < 4; i++) begin
      advance();
      rb = 4'b1011;
      if (m_mode == 1 && m_held == 4) rb[m_owner] = 1'b0;
      drive(rb, '0, '0, -1);
    end
    log_en = 1'b0;
    chk("rr_count", 64'(glog.size()), 64'(4));
    for (int i = 0; i < 4 && i < glog.size(); i++) chk("rr_order", 64'(glog[i]), 64'(exp_order[i]));
    repeat (6) step('0, '0, '0, -1);

    // read on the last owned cycle returns during drain
    hit_reset(1'b0);
    ret_seen = 0;
    begin
      bit done;
      done = 1'b0;
      for (int i = 0; i < 14; i++) begin
        advance();
        if (!done && m_mode == 1 && m_held == 3) begin
          drive('0, '0, 4'b0010, 'h155);
          done = 1'b1;
        end else begin
          drive(done ? 4'b0000 : 4'b0010, '0, '0, -1);
        end
      end
    end
    chk("rd_ret_count", 64'(ret_seen), 64'(1));
    chk("rd_ret_value", 64'(last_ret), 64'(48'h000000ABC000));

    // drops from non-owners, then saturation
    hit_reset(1'b0);
    step(4'b0001, '0, '0, -1);
    step(4'b0001, 4'b1000, '0, -1);
    step(4'b0001, 4'b1100, '0, -1);
    step(4'b0001, 4'b1000, '0, -1);
    step(4'b0001, '0, '0, -1);
    chk("drop_three", 64'(drop_cnt), 64'(3));
    repeat (300) step(4'b0001, 4'b1000, '0, -1);
    step('0, '0, '0, -1);
    chk("drop_sat", 64'(drop_cnt), 64'(DROP_MAX));
    repeat (4) step('0, '0, '0, -1);

    // watchdog with a lone requester: regranted to the same channel
    hit_reset(1'b0);
    wd_seen = 0;
    glog.delete();
    log_en = 1'b1;
    repeat (24) step(4'b0001, '0, '0, -1);
    log_en = 1'b0;
    chk("wd_lone_pulses", 64'(wd_seen), 64'(1));
    chk("wd_lone_grants", 64'(glog.size()), 64'(2));
    if (glog.size() >= 2) chk("wd_lone_regrant", 64'(glog[1]), 64'(4'b0001));
    repeat (6) step('0, '0, '0, -1);

    // watchdog with a competing requester: ownership moves to ch2
    hit_reset(1'b0);
    wd_seen = 0;
    glog.delete();
    log_en = 1'b1;
    repeat (24) step(4'b0101, '0, '0, -1);
    log_en = 1'b0;
    chk("wd_pair_pulses", 64'(wd_seen), 64'(1));
    chk("wd_pair_grants", 64'(glog.size()), 64'(2));
    if (glog.size() >= 2) chk("wd_pair_next", 64'(glog[1]), 64'(4'b0100));
    repeat (6) step('0, '0, '0, -1);

    // randomised traffic
    hit_reset(1'b0);
    rb = '0;
    for (int i = 0; i < 600; i++) begin
      for (int c = 0; c < CH; c++) if ($urandom_range(0, 9) == 0) rb[c] = ~rb[c];
      step(rb, CH'($urandom), CH'($urandom) & CH'($urandom), -1);
    end
    repeat (6) step('0, '0, '0, -1);

    // reset while owning with reads in flight
    hit_reset(1'b0);
    step(4'b0010, '0, '0, -1);
    step(4'b0010, '0, 4'b0010, -1);
    step(4'b0010, '0, 4'b0010, -1);
    hit_reset(1'b1);
    ret_seen = 0;
    repeat (6) step('0, '0, '0, -1);
    chk("rst_no_return", 64'(ret_seen), 64'(0));

    mon_en = 1'b0;
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
